// File: rtl/i2c_reg_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_xfer_ctrl
//  Brief    : Register-access transaction sequencer driving an I2C byte
//             controller (START/addr/reg/data/repeated START/STOP).
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_reg_xfer_ctrl #(
    parameter  int MAX_BYTES = 4,
    localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_rw_i,
    input  logic [6:0]             cmd_dev_addr_i,
    input  logic [7:0]             cmd_reg_addr_i,
    input  logic [LEN_W-1:0]       cmd_len_i,
    input  logic [8*MAX_BYTES-1:0] cmd_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [8*MAX_BYTES-1:0] rsp_rdata_o,
    output logic [1:0]             rsp_err_o,
    output logic                   busy_o,
    output logic                   start_o,
    output logic                   stop_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic                   ack_in_o,
    output logic [7:0]             din_o,
    input  logic                   cmd_ack_i,
    input  logic                   ack_out_i,
    input  logic [7:0]             dout_i,
    input  logic                   i2c_al_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DEV_W = 3'd1,
        S_REG   = 3'd2,
        S_WDATA = 3'd3,
        S_DEV_R = 3'd4,
        S_RDATA = 3'd5,
        S_STOP  = 3'd6,
        S_RESP  = 3'd7
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_gap, w_gap_nxt;
    logic                   r_rw, w_rw_nxt;
    logic [6:0]             r_dev, w_dev_nxt;
    logic [7:0]             r_reg, w_reg_nxt;
    logic [LEN_W-1:0]       r_len, w_len_nxt;
    logic [LEN_W-1:0]       r_idx, w_idx_nxt;
    logic [8*MAX_BYTES-1:0] r_wdata, w_wdata_nxt;
    logic [8*MAX_BYTES-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]             r_err, w_err_nxt;
    logic                   r_start, w_start_nxt;
    logic                   r_stop, w_stop_nxt;
    logic                   r_read, w_read_nxt;
    logic                   r_write, w_write_nxt;
    logic                   r_ack_in, w_ack_in_nxt;
    logic [7:0]             r_din, w_din_nxt;
    logic                   r_rsp_valid, w_rsp_valid_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_ready, w_ready_nxt;
    logic [7:0]             w_wbyte;
    logic                   w_last;
    logic                   w_wr_state;
    logic                   w_accept;

    assign w_accept = cmd_valid_i & r_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_gap_nxt    = r_gap;
        w_rw_nxt     = r_rw;
        w_dev_nxt    = r_dev;
        w_reg_nxt    = r_reg;
        w_len_nxt    = r_len;
        w_idx_nxt    = r_idx;
        w_wdata_nxt  = r_wdata;
        w_rdata_nxt  = r_rdata;
        w_err_nxt    = r_err;
        w_start_nxt  = r_start;
        w_stop_nxt   = r_stop;
        w_read_nxt   = r_read;
        w_write_nxt  = r_write;
        w_ack_in_nxt = r_ack_in;
        w_din_nxt    = r_din;
        w_wbyte      = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (r_idx == LEN_W'(i)) begin
                w_wbyte = r_wdata[i*8 +: 8];
            end
        end
        w_last     = (r_idx == r_len - LEN_W'(1));
        w_wr_state = (r_state == S_DEV_W) || (r_state == S_REG) ||
                     (r_state == S_WDATA) || (r_state == S_DEV_R);

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_rw_nxt    = cmd_rw_i;
                    w_dev_nxt   = cmd_dev_addr_i;
                    w_reg_nxt   = cmd_reg_addr_i;
                    w_len_nxt   = cmd_len_i;
                    w_wdata_nxt = cmd_wdata_i;
                    w_rdata_nxt = '0;
                    w_err_nxt   = 2'b00;
                    w_idx_nxt   = '0;
                    w_gap_nxt   = 1'b0;
                    if ((cmd_len_i > LEN_W'(MAX_BYTES)) || (cmd_rw_i && (cmd_len_i == '0))) begin
                        w_err_nxt   = 2'b11;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_DEV_W;
                        w_start_nxt = 1'b1;
                        w_write_nxt = 1'b1;
                        w_din_nxt   = {cmd_dev_addr_i, 1'b0};
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                // Arbitration loss wins over a coincident cmd_ack; the bus is gone, so no STOP.
                if (i2c_al_i) begin
                    w_start_nxt  = 1'b0;
                    w_stop_nxt   = 1'b0;
                    w_read_nxt   = 1'b0;
                    w_write_nxt  = 1'b0;
                    w_ack_in_nxt = 1'b0;
                    w_gap_nxt    = 1'b0;
                    w_err_nxt    = 2'b10;
                    w_state_nxt  = S_RESP;
                end else if (r_gap) begin
                    w_gap_nxt = 1'b0;
                    case (r_state)
                        S_REG: begin
                            w_write_nxt = 1'b1;
                            w_din_nxt   = r_reg;
                        end
                        S_WDATA: begin
                            w_write_nxt = 1'b1;
                            w_din_nxt   = w_wbyte;
                        end
                        S_DEV_R: begin
                            w_start_nxt = 1'b1;
                            w_write_nxt = 1'b1;
                            w_din_nxt   = {r_dev, 1'b1};
                        end
                        S_RDATA: begin
                            w_read_nxt   = 1'b1;
                            w_ack_in_nxt = w_last;
                        end
                        S_STOP: begin
                            w_stop_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (cmd_ack_i) begin
                    w_start_nxt  = 1'b0;
                    w_stop_nxt   = 1'b0;
                    w_read_nxt   = 1'b0;
                    w_write_nxt  = 1'b0;
                    w_ack_in_nxt = 1'b0;
                    w_gap_nxt    = 1'b1;
                    if (w_wr_state && ack_out_i) begin
                        w_err_nxt   = 2'b01;
                        w_state_nxt = S_STOP;
                    end else begin
                        case (r_state)
                            S_DEV_W: w_state_nxt = S_REG;
                            S_REG: begin
                                w_idx_nxt = '0;
                                if (r_rw) begin
                                    w_state_nxt = S_DEV_R;
                                end else if (r_len == '0) begin
                                    w_state_nxt = S_STOP;
                                end else begin
                                    w_state_nxt = S_WDATA;
                                end
                            end
                            S_WDATA: begin
                                if (w_last) begin
                                    w_state_nxt = S_STOP;
                                end else begin
                                    w_idx_nxt = r_idx + LEN_W'(1);
                                end
                            end
                            S_DEV_R: begin
                                w_idx_nxt   = '0;
                                w_state_nxt = S_RDATA;
                            end
                            S_RDATA: begin
                                for (int i = 0; i < MAX_BYTES; i++) begin
                                    if (r_idx == LEN_W'(i)) begin
                                        w_rdata_nxt[i*8 +: 8] = dout_i;
                                    end
                                end
                                if (w_last) begin
                                    w_state_nxt = S_STOP;
                                end else begin
                                    w_idx_nxt = r_idx + LEN_W'(1);
                                end
                            end
                            S_STOP: begin
                                w_gap_nxt   = 1'b0;
                                w_state_nxt = S_RESP;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        w_rsp_valid_nxt = (w_state_nxt == S_RESP);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_ready_nxt     = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_gap       <= 1'b0;
            r_rw        <= 1'b0;
            r_dev       <= '0;
            r_reg       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 2'b00;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_ack_in    <= 1'b0;
            r_din       <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gap       <= w_gap_nxt;
            r_rw        <= w_rw_nxt;
            r_dev       <= w_dev_nxt;
            r_reg       <= w_reg_nxt;
            r_len       <= w_len_nxt;
            r_idx       <= w_idx_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
            r_start     <= w_start_nxt;
            r_stop      <= w_stop_nxt;
            r_read      <= w_read_nxt;
            r_write     <= w_write_nxt;
            r_ack_in    <= w_ack_in_nxt;
            r_din       <= w_din_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_ready     <= w_ready_nxt;
        end
    end

    assign cmd_ready_o = r_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
    assign busy_o      = r_busy;
    assign start_o     = r_start;
    assign stop_o      = r_stop;
    assign read_o      = r_read;
    assign write_o     = r_write;
    assign ack_in_o    = r_ack_in;
    assign din_o       = r_din;

endmodule
`default_nettype wire
